data_memory_mmio: RTL and testbench

- Byte-addressed successor to the word-indexed data memory of the RV32I single-cycle core.
- Supports full RV32I load/store widths (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte lanes and misalignment detection.
- Provides parametrised memory-mapped IO: N output channel registers; a synchronised input port; a sticky rising-edge capture register with write-1-to-clear; and a maskable interrupt.
- Sits between the core's ALU result/rs2 path and the board IO (switches, keys, LEDs, HEX).

---
 rtl/data_memory_mmio.sv | 151 +++++++++++++++
 tb/tb_data_memory_mmio.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_mmio.sv
// Byte-addressed data memory with RV32I load/store lanes and a small MMIO block:
// output channel registers, synchronised inputs, sticky rising-edge capture and a maskable irq.
module data_memory_mmio #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned IO_BASE_ADDR = 256,
  parameter int unsigned IN_WIDTH     = 14,
  parameter int unsigned N_OUT_CH     = 7,
  parameter int unsigned OUT_CH_WIDTH = 10
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [XLEN-1:0]                  address,
  input  logic [2:0]                       funct3,
  input  logic                             write_enable,
  input  logic [XLEN-1:0]                  write_data,
  output logic [XLEN-1:0]                  read_data,
  output logic                             misaligned,
  input  logic [IN_WIDTH-1:0]              io_input_bus,
  output logic [N_OUT_CH*OUT_CH_WIDTH-1:0] io_output_bus,
  output logic                             irq
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW        = (N_OUT_CH > 1) ? $clog2(N_OUT_CH) : 1;
  localparam int unsigned RAM_BYTES = 4 * DEPTH;
  localparam int unsigned IN_WORD   = 16;
  localparam int unsigned EDGE_WORD = 17;
  localparam int unsigned MASK_WORD = 18;

  logic [XLEN-1:0]         ram [DEPTH];
  logic [OUT_CH_WIDTH-1:0] out_reg [N_OUT_CH];
  logic [IN_WIDTH-1:0]     mask_reg;
  logic [IN_WIDTH-1:0]     edge_reg;
  logic [IN_WIDTH-1:0]     s1, s2, s3;
  logic [IN_WIDTH-1:0]     edge_vec;
  logic [IN_WIDTH-1:0]     clr;

  logic            is_byte, is_half, is_word, zext, width_ok, misal, acc_ok;
  logic            in_io, ram_hit, sel_out, sel_in, sel_edge, sel_mask;
  logic [XLEN-1:0] io_word;
  logic [OW-1:0]   out_idx;
  logic [AW-1:0]   ram_idx;
  logic [4:0]      byte_sh;
  logic [XLEN-1:0] cur_word, shifted, lane_mask, wr_aligned, merged;
  logic            do_write;

  // Access width and alignment decode
  always_comb begin
    is_byte  = (funct3[1:0] == 2'b00);
    is_half  = (funct3[1:0] == 2'b01);
    is_word  = (funct3 == 3'b010);
    zext     = funct3[2];
    width_ok = is_byte | is_half | is_word;
    misal    = (is_half & address[0]) | (is_word & (address[1:0] != 2'b00));
    acc_ok   = width_ok & ~misal;
  end

  assign misaligned = misal;

  // Address map decode
  always_comb begin
    in_io    = (address >= XLEN'(IO_BASE_ADDR));
    io_word  = (address - XLEN'(IO_BASE_ADDR)) >> 2;
    ram_hit  = (address < XLEN'(RAM_BYTES));
    sel_out  = in_io && (io_word < XLEN'(N_OUT_CH));
    sel_in   = in_io && (io_word == XLEN'(IN_WORD));
    sel_edge = in_io && (io_word == XLEN'(EDGE_WORD));
    sel_mask = in_io && (io_word == XLEN'(MASK_WORD));
    out_idx  = io_word[OW-1:0];
    ram_idx  = address[AW+1:2];
  end

  // Current word of the addressed location, zero-extended
  always_comb begin
    cur_word = '0;
    if (ram_hit)       cur_word = ram[ram_idx];
    else if (sel_out)  cur_word = XLEN'(out_reg[out_idx]);
    else if (sel_in)   cur_word = XLEN'(s2);
    else if (sel_edge) cur_word = XLEN'(edge_reg);
    else if (sel_mask) cur_word = XLEN'(mask_reg);
  end

  // Store lane placement and merge
  always_comb begin
    byte_sh    = {address[1:0], 3'b000};
    lane_mask  = '0;
    wr_aligned = '0;
    if (acc_ok) begin
      if (is_byte) begin
        lane_mask  = XLEN'(8'hFF) << byte_sh;
        wr_aligned = XLEN'(write_data[7:0]) << byte_sh;
      end else if (is_half) begin
        lane_mask  = XLEN'(16'hFFFF) << byte_sh;
        wr_aligned = XLEN'(write_data[15:0]) << byte_sh;
      end else begin
        lane_mask  = '1;
        wr_aligned = write_data;
      end
    end
    merged   = (cur_word & ~lane_mask) | wr_aligned;
    do_write = write_enable & acc_ok & ~reset;
    clr      = (do_write && sel_edge) ? wr_aligned[IN_WIDTH-1:0] : '0;
  end

  // Load lane select and extension
  always_comb begin
    shifted   = cur_word >> byte_sh;
    read_data = '0;
    if (acc_ok) begin
      if (is_byte)
        read_data = zext ? XLEN'(shifted[7:0]) : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      else if (is_half)
        read_data = zext ? XLEN'(shifted[15:0]) : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      else
        read_data = shifted;
    end
  end

  assign edge_vec = s2 & ~s3;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) ram[i] <= '0;
      for (int k = 0; k < int'(N_OUT_CH); k++) out_reg[k] <= '0;
      mask_reg <= '0;
      edge_reg <= '0;
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      irq      <= 1'b0;
    end else begin
      s1       <= io_input_bus;
      s2       <= s1;
      s3       <= s2;
      // Set beats clear when a new edge and a W1C land in the same cycle
      edge_reg <= (edge_reg & ~clr) | edge_vec;
      irq      <= |(edge_reg & mask_reg);
      if (do_write) begin
        if (ram_hit)       ram[ram_idx]     <= merged;
        else if (sel_out)  out_reg[out_idx] <= merged[OUT_CH_WIDTH-1:0];
        else if (sel_mask) mask_reg         <= merged[IN_WIDTH-1:0];
      end
    end
  end

  for (genvar k = 0; k < N_OUT_CH; k++) begin : g_out
    assign io_output_bus[k*OUT_CH_WIDTH +: OUT_CH_WIDTH] = out_reg[k];
  end

endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed scoreboard bench for data_memory_mmio: loads/stores, MMIO channels, edge capture, irq, reset.
module tb_data_memory_mmio;

  localparam int unsigned XLEN = 32;
  localparam int unsigned INW  = 14;
  localparam int unsigned NCH  = 7;
  localparam int unsigned OCW  = 10;
  localparam logic [31:0] IO   = 32'd256;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  logic                 clock;
  logic                 reset;
  logic [XLEN-1:0]      address;
  logic [2:0]           funct3;
  logic                 write_enable;
  logic [XLEN-1:0]      write_data;
  logic [XLEN-1:0]      read_data;
  logic                 misaligned;
  logic [INW-1:0]       io_input_bus;
  logic [NCH*OCW-1:0]   io_output_bus;
  logic                 irq;

  data_memory_mmio dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .funct3       (funct3),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_data    (read_data),
    .misaligned   (misaligned),
    .io_input_bus (io_input_bus),
    .io_output_bus(io_output_bus),
    .irq          (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string        tag;
    logic [127:0] val;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic push(input string tag, input logic [127:0] v);
    sb_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [127:0] obs);
    sb_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=0x%0h expected=entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f, input string tag,
                      input logic [31:0] exp);
    address      = a;
    funct3       = f;
    write_enable = 1'b0;
    push(tag, 128'(exp));
    #1;
    pop_check(128'(read_data));
  endtask

  task automatic store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    @(negedge clock);
    address      = a;
    funct3       = f;
    write_data   = d;
    write_enable = 1'b1;
    @(posedge clock);
    #1;
    write_enable = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_irq(input string tag, input logic exp);
    push(tag, 128'(exp));
    pop_check(128'(irq));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    address      = '0;
    funct3       = F_W;
    write_enable = 1'b0;
    write_data   = '0;
    io_input_bus = '0;
    repeat (2) @(posedge clock);
    #1;
    push("rst_bus", 128'(0));
    pop_check(128'(io_output_bus));
    check_irq("rst_irq", 1'b0);
    load(32'h10, F_W, "rst_ram", 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Load widths and sign handling
    store(32'h10, F_W, 32'hDEADBEEF);
    load(32'h10, F_W,  "lw_10",  32'hDEADBEEF);
    load(32'h10, F_B,  "lb_10",  32'hFFFFFFEF);
    load(32'h13, F_B,  "lb_13",  32'hFFFFFFDE);
    load(32'h13, F_BU, "lbu_13", 32'h000000DE);
    load(32'h12, F_H,  "lh_12",  32'hFFFFDEAD);
    load(32'h12, F_HU, "lhu_12", 32'h0000DEAD);

    // Byte/half stores and misalignment
    store(32'h10, F_W, 32'h0);
    store(32'h11, F_B, 32'hFFFFFFAA);
    load(32'h10, F_W, "sb_merge", 32'h0000AA00);
    @(negedge clock);
    address = 32'h11; funct3 = F_H; write_data = 32'hFFFF; write_enable = 1'b1;
    push("sh_misal", 128'(1));
    #1;
    pop_check(128'(misaligned));
    @(posedge clock);
    #1;
    write_enable = 1'b0;
    load(32'h10, F_W, "sh_misal_nowrite", 32'h0000AA00);
    load(32'h12, F_W, "lw_misal_rd", 32'h0);
    push("lw_misal_flag", 128'(1));
    pop_check(128'(misaligned));
    load(32'h10, 3'b011, "f3_011_rd", 32'h0);
    push("f3_011_flag", 128'(0));
    pop_check(128'(misaligned));
    store(32'h12, F_H, 32'hCAFE1234);
    load(32'h10, F_W,  "sh_merge", 32'h1234AA00);
    load(32'h12, F_HU, "lhu_sh",   32'h00001234);
    store(32'hFC, F_W, 32'h55);
    load(32'hFC, F_W, "ram_last", 32'h55);

    // Output channels
    store(IO + 32'h00, F_W, 32'h3FF);
    store(IO + 32'h18, F_W, 32'h7F);
    store(IO + 32'h04, F_W, 32'hFFFFFFFF);
    push("out_bus", (128'h7F << 60) | (128'h3FF << 10) | 128'h3FF);
    pop_check(128'(io_output_bus));
    load(IO + 32'h00, F_W, "out0_rd", 32'h3FF);
    load(IO + 32'h04, F_W, "out1_trunc", 32'h3FF);
    load(IO + 32'h40, F_W, "in_idle", 32'h0);
    store(IO + 32'h1C, F_W, 32'h12345678);
    load(IO + 32'h1C, F_W, "unmapped_rd", 32'h0);
    push("out_bus_after_unmapped", (128'h7F << 60) | (128'h3FF << 10) | 128'h3FF);
    pop_check(128'(io_output_bus));

    // Input sync, edge capture, irq
    store(IO + 32'h48, F_W, 32'hFFFF2000);
    load(IO + 32'h48, F_W, "mask_rd", 32'h2000);
    @(negedge clock);
    io_input_bus = 14'h2000;
    tick();
    load(IO + 32'h40, F_W, "in_1clk", 32'h0);
    tick();
    load(IO + 32'h40, F_W, "in_2clk", 32'h2000);
    load(IO + 32'h44, F_W, "edge_2clk", 32'h0);
    tick();
    load(IO + 32'h44, F_W, "edge_3clk", 32'h2000);
    check_irq("irq_lag", 1'b0);
    tick();
    check_irq("irq_set", 1'b1);
    store(IO + 32'h44, F_W, 32'h2000);
    load(IO + 32'h44, F_W, "edge_w1c", 32'h0);
    check_irq("irq_hold", 1'b1);
    tick();
    check_irq("irq_drop", 1'b0);

    // Edge set wins over a same-cycle clear
    @(negedge clock);
    io_input_bus = 14'h2001;
    repeat (3) tick();
    load(IO + 32'h44, F_W, "edge_bit0", 32'h0001);
    @(negedge clock);
    io_input_bus = 14'h2000;
    repeat (3) tick();
    store(IO + 32'h44, F_W, 32'h0001);
    load(IO + 32'h44, F_W, "edge_bit0_clr", 32'h0);
    @(negedge clock);
    io_input_bus = 14'h2001;
    @(posedge clock);
    @(posedge clock);
    store(IO + 32'h44, F_W, 32'h0001);
    load(IO + 32'h44, F_W, "set_wins", 32'h0001);
    store(IO + 32'h48, F_W, 32'h2001);
    tick();
    check_irq("irq_bit0", 1'b1);

    // Reset clears state; store during reset dropped; held input recaptured
    @(negedge clock);
    reset = 1'b1;
    tick();
    push("rst2_bus", 128'(0));
    pop_check(128'(io_output_bus));
    check_irq("rst2_irq", 1'b0);
    load(32'h10, F_W, "rst2_ram10", 32'h0);
    load(32'hFC, F_W, "rst2_ramfc", 32'h0);
    load(IO + 32'h48, F_W, "rst2_mask", 32'h0);
    load(IO + 32'h44, F_W, "rst2_edge", 32'h0);
    store(32'h20, F_W, 32'h77);
    @(negedge clock);
    reset = 1'b0;
    tick();
    load(32'h20, F_W, "rst_store_drop", 32'h0);
    load(IO + 32'h44, F_W, "post_rst_edge1", 32'h0);
    tick();
    load(IO + 32'h40, F_W, "post_rst_in2", 32'h2001);
    load(IO + 32'h44, F_W, "post_rst_edge2", 32'h0);
    tick();
    load(IO + 32'h44, F_W, "post_rst_edge3", 32'h2001);
    check_irq("post_rst_irq", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
